// File: rtl/iguana_eoc_monitor.sv
// rtl/iguana_eoc_monitor.sv - multi-channel EOC monitor with power-up sequencer, timeout and progress ticks
// Optional all-channels-must-report mode: IGUANA_EOC_ALL_EN.
module iguana_eoc_monitor #(
  parameter int NumChannels    = 2,
  parameter int DataWidth      = 32,
  parameter int PowerupCycles  = 60000,
  parameter int NumItvs        = 5,
  parameter int TimeoutCycles  = 1000000,
  parameter int ProgressCycles = 100000,
  localparam int ItvW  = $clog2(NumItvs + 1),
  localparam int ChanW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic                             clear_i,
  input  logic [NumChannels-1:0]           eoc_valid_i,
  input  logic [NumChannels*DataWidth-1:0] eoc_data_i,
  output logic                             powerup_done_o,
  output logic                             itv_tick_o,
  output logic [ItvW-1:0]                  itv_idx_o,
  output logic                             progress_tick_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             timeout_o,
  output logic                             pass_o,
  output logic [DataWidth-2:0]             exit_code_o,
`ifdef IGUANA_EOC_ALL_EN
  output logic [NumChannels-1:0]           reported_o,
`endif
  output logic [ChanW-1:0]                 exit_chan_o
);

  localparam int PuW = $clog2(PowerupCycles + 1);
  localparam int ToW = $clog2(TimeoutCycles + 1);
  localparam int PgW = $clog2(ProgressCycles + 2);
  localparam logic [PuW-1:0] PuTotal  = PuW'(PowerupCycles);
  localparam logic [PuW-1:0] PuLen    = PuW'(PowerupCycles / NumItvs);
  localparam logic [PuW-1:0] FirstEnd = (NumItvs == 1) ? PuTotal : PuLen;

  typedef enum logic [2:0] {S_IDLE, S_POWERUP, S_RUN, S_DONE, S_TIMEOUT} state_t;
  state_t state_q;

  // pu_cnt_q holds the 1-based number of the current power-up cycle; end_q the next interval end
  logic [PuW-1:0] pu_cnt_q, end_q;
  logic [ToW-1:0] to_cnt_q;
  logic [PgW-1:0] pg_cnt_q;

  logic [PuW-1:0]  adv_cyc, adv_end, end_next;
  logic [ItvW-1:0] adv_idx, idx_next;
  logic            itv_hit;

  // Interval bookkeeping for the upcoming cycle; from IDLE it is evaluated for cycle 1
  always_comb begin
    adv_cyc  = (state_q == S_POWERUP) ? pu_cnt_q + 1'b1 : PuW'(1);
    adv_end  = (state_q == S_POWERUP) ? end_q : FirstEnd;
    adv_idx  = (state_q == S_POWERUP) ? itv_idx_o : '0;
    itv_hit  = (adv_cyc == adv_end);
    idx_next = adv_idx;
    end_next = adv_end;
    if (itv_hit) begin
      idx_next = (adv_idx == ItvW'(NumItvs)) ? adv_idx : adv_idx + 1'b1;
      end_next = (int'(adv_idx) + 2 >= NumItvs) ? PuTotal : adv_end + PuLen;
    end
  end

  logic [ToW-1:0] to_next;
  logic [PgW-1:0] pg_next;
  logic           to_hit, pg_hit;

  assign to_next = to_cnt_q + 1'b1;
  assign pg_next = pg_cnt_q + 1'b1;
  assign to_hit  = (to_next == ToW'(TimeoutCycles));
  assign pg_hit  = (ProgressCycles != 0) && (pg_next == PgW'(ProgressCycles));

  logic                 rep_hit;
  logic [ChanW-1:0]     rep_chan;
  logic [DataWidth-2:0] rep_code;

`ifdef IGUANA_EOC_ALL_EN
  logic [NumChannels-1:0] reported_q, rep_vec;
  logic [DataWidth-2:0]   acc_q, or_code;

  // Run completes once every channel has reported; the newest reporter with the highest index is named
  always_comb begin
    rep_vec  = '0;
    or_code  = '0;
    rep_chan = '0;
    for (int k = 0; k < NumChannels; k++) begin
      rep_vec[k] = eoc_valid_i[k] && eoc_data_i[k*DataWidth];
      if (rep_vec[k]) begin
        or_code = or_code | eoc_data_i[k*DataWidth+1 +: DataWidth-1];
        if (!reported_q[k]) rep_chan = ChanW'(k);
      end
    end
    rep_hit  = &(reported_q | rep_vec);
    rep_code = acc_q | or_code;
  end

  assign reported_o = reported_q;
`else
  // Descending scan so the lowest reporting index is the one left standing
  always_comb begin
    rep_hit  = 1'b0;
    rep_chan = '0;
    rep_code = '0;
    for (int k = NumChannels - 1; k >= 0; k--) begin
      if (eoc_valid_i[k] && eoc_data_i[k*DataWidth]) begin
        rep_hit  = 1'b1;
        rep_chan = ChanW'(k);
        rep_code = eoc_data_i[k*DataWidth+1 +: DataWidth-1];
      end
    end
  end
`endif

  assign busy_o = (state_q == S_POWERUP) || (state_q == S_RUN);
  assign pass_o = done_o && (exit_code_o == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_IDLE;
      pu_cnt_q        <= '0;
      end_q           <= '0;
      to_cnt_q        <= '0;
      pg_cnt_q        <= '0;
      itv_idx_o       <= '0;
      itv_tick_o      <= 1'b0;
      progress_tick_o <= 1'b0;
      powerup_done_o  <= 1'b0;
      done_o          <= 1'b0;
      timeout_o       <= 1'b0;
      exit_code_o     <= '0;
      exit_chan_o     <= '0;
`ifdef IGUANA_EOC_ALL_EN
      reported_q      <= '0;
      acc_q           <= '0;
`endif
    end else if (clear_i) begin
      state_q         <= S_IDLE;
      pu_cnt_q        <= '0;
      end_q           <= '0;
      to_cnt_q        <= '0;
      pg_cnt_q        <= '0;
      itv_idx_o       <= '0;
      itv_tick_o      <= 1'b0;
      progress_tick_o <= 1'b0;
      powerup_done_o  <= 1'b0;
      done_o          <= 1'b0;
      timeout_o       <= 1'b0;
      exit_code_o     <= '0;
      exit_chan_o     <= '0;
`ifdef IGUANA_EOC_ALL_EN
      reported_q      <= '0;
      acc_q           <= '0;
`endif
    end else begin
      itv_tick_o      <= 1'b0;
      progress_tick_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_POWERUP;
            pu_cnt_q   <= adv_cyc;
            end_q      <= end_next;
            itv_idx_o  <= idx_next;
            itv_tick_o <= itv_hit;
            to_cnt_q   <= '0;
            pg_cnt_q   <= '0;
`ifdef IGUANA_EOC_ALL_EN
            reported_q <= '0;
            acc_q      <= '0;
`endif
          end
        end
        S_POWERUP: begin
          to_cnt_q <= to_next;
          pg_cnt_q <= pg_hit ? '0 : pg_next;
          if (to_hit) begin
            state_q   <= S_TIMEOUT;
            timeout_o <= 1'b1;
          end else begin
            progress_tick_o <= pg_hit;
            if (pu_cnt_q == PuTotal) begin
              state_q        <= S_RUN;
              powerup_done_o <= 1'b1;
            end else begin
              pu_cnt_q   <= adv_cyc;
              end_q      <= end_next;
              itv_idx_o  <= idx_next;
              itv_tick_o <= itv_hit;
            end
          end
        end
        S_RUN: begin
          to_cnt_q <= to_next;
          pg_cnt_q <= pg_hit ? '0 : pg_next;
`ifdef IGUANA_EOC_ALL_EN
          reported_q <= reported_q | rep_vec;
          acc_q      <= acc_q | or_code;
`endif
          if (rep_hit) begin
            state_q     <= S_DONE;
            done_o      <= 1'b1;
            exit_code_o <= rep_code;
            exit_chan_o <= rep_chan;
          end else if (to_hit) begin
            state_q   <= S_TIMEOUT;
            timeout_o <= 1'b1;
          end else begin
            progress_tick_o <= pg_hit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
